instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Purpose: receives a byte stream, packs it little-endian into 32-bit words and writes them to instruction memory while holding the core.
// Latency: one imem_we cycle follows the edge that accepts each 4th byte; done rises the cycle after the final write (or after the checksum byte).
// Backpressure: byte_ready is high only in RECV/CHECK; optional trailing checksum byte enabled by macro LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [ADDR_WIDTH:0]   len_q;
    logic [23:0]           asm_q;
    logic                  err_q;
    logic                  len_ok;
    logic                  start_ok;
    logic                  byte_take;
    logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // A zero length or one larger than the memory depth is rejected up front.
    assign len_ok    = (length != '0) && (length <= LEN_MAX);
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign byte_take = (state == RECV) && byte_valid;
    // Index never reaches len_q, so it stays inside the memory depth.
    assign last_word = (({1'b0, word_idx} + LEN_ONE) >= len_q);

    // Core stays held during a load and after any failed load.
    assign core_hold = (state != DONE) || err_q;
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = len_ok ? RECV : DONE;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (byte_valid && (lane == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (!last_word) begin
                    state_nxt = RECV;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = len_ok ? RECV : DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: word assembly, write address/data capture, index and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx   <= '0;
            lane       <= 2'd0;
            len_q      <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            if (start_ok) begin
                word_idx <= '0;
                lane     <= 2'd0;
                len_q    <= length;
                err_q    <= !len_ok;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (byte_take) begin
                lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum + byte_data;
`endif
                case (lane)
                    2'd0: asm_q[7:0]   <= byte_data;
                    2'd1: asm_q[15:8]  <= byte_data;
                    2'd2: asm_q[23:16] <= byte_data;
                    default: begin
                        // Address/data only move when a complete word is ready,
                        // so they hold the last write between pulses.
                        imem_addr  <= {{(30-ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
                        imem_wdata <= {byte_data, asm_q};
                    end
                endcase
            end
            if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if ((state == CHECK) && byte_valid) begin
                err_q <= (byte_data != csum);
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Purpose: directed self-checking bench for instr_mem_loader (both macro settings).
// Latency: inputs driven 1ns after rising edge, outputs sampled on falling edge.
// Backpressure: bytes are held valid until byte_ready is seen, bounded waits.
module tb_instr_mem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int base     = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    localparam logic [7:0] PROG [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every cycle the write strobe is high.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] len);
        length = len;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!byte_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_prog(input int gap);
        for (int i = 0; i < 8; i++) send_byte(PROG[i], gap);
    endtask

    // Leaves the caller at a falling edge with done sampled.
    task automatic wait_done(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!done && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_prog_writes(input string tag);
        check({tag, "_nwr"},   32'(wr_addr_q.size() - base), 32'd2);
        check({tag, "_addr0"}, wr_addr_q[base],     32'h0000_0000);
        check({tag, "_data0"}, wr_data_q[base],     32'h0050_0013);
        check({tag, "_addr1"}, wr_addr_q[base + 1], 32'h0000_0004);
        check({tag, "_data1"}, wr_data_q[base + 1], 32'h0010_0093);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values while reset is held low.
        @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  imem_addr,       32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_core_hold",  32'(core_hold),  32'd1);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("idle_wait_ready", 32'(byte_ready), 32'd0);
        check("idle_wait_done",  32'(done),       32'd0);
        tick();

        // Two words back-to-back.
        base = wr_addr_q.size();
        do_start(2);
        @(negedge clk);
        check("b2b_hold_loading", 32'(core_hold),  32'd1);
        check("b2b_ready_recv",   32'(byte_ready), 32'd1);
        tick();
        send_prog(0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        wait_done("b2b_done");
        check("b2b_err",       32'(err),       32'd0);
        check("b2b_core_hold", 32'(core_hold), 32'd0);
        check_prog_writes("b2b");
        check("b2b_addr_hold", imem_addr,  32'h0000_0004);
        check("b2b_data_hold", imem_wdata, 32'h0010_0093);
        tick();

        // Same stream with three idle cycles after every byte.
        base = wr_addr_q.size();
        do_start(2);
        @(negedge clk);
        check("gap_done_cleared", 32'(done),      32'd0);
        check("gap_hold_again",   32'(core_hold), 32'd1);
        tick();
        send_prog(3);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        wait_done("gap_done");
        check("gap_err", 32'(err), 32'd0);
        check_prog_writes("gap");
        tick();

        // Start during RECV must be ignored.
        base = wr_addr_q.size();
        do_start(2);
        for (int i = 0; i < 3; i++) send_byte(PROG[i], 0);
        length = 9'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 3; i < 8; i++) send_byte(PROG[i], 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        wait_done("ign_done");
        check("ign_err", 32'(err), 32'd0);
        check_prog_writes("ign");
        tick();

        // Illegal lengths.
        base = wr_addr_q.size();
        do_start(0);
        @(negedge clk);
        check("len0_done",      32'(done),       32'd1);
        check("len0_err",       32'(err),        32'd1);
        check("len0_core_hold", 32'(core_hold),  32'd1);
        check("len0_ready",     32'(byte_ready), 32'd0);
        tick();
        do_start(9'd257);
        @(negedge clk);
        check("len257_done",      32'(done),      32'd1);
        check("len257_err",       32'(err),       32'd1);
        check("len257_core_hold", 32'(core_hold), 32'd1);
        repeat (3) @(negedge clk);
        check("badlen_nwr", 32'(wr_addr_q.size() - base), 32'd0);
        tick();

        // Full-depth load: byte n carries value n mod 256.
        base = wr_addr_q.size();
        do_start(9'd256);
        for (int i = 0; i < 1024; i++) send_byte(8'(i), 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_done("max_done");
        check("max_err",       32'(err), 32'd0);
        check("max_nwr",       32'(wr_addr_q.size() - base), 32'd256);
        check("max_data0",     wr_data_q[base],       32'h0302_0100);
        check("max_addr_last", wr_addr_q[base + 255], 32'h0000_03FC);
        check("max_data_last", wr_data_q[base + 255], 32'hFFFE_FDFC);
        tick();

        // Reset after six bytes of a two-word load.
        base = wr_addr_q.size();
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(PROG[i], 0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready",     32'(byte_ready), 32'd0);
        check("mid_rst_we",        32'(imem_we),    32'd0);
        check("mid_rst_addr",      imem_addr,       32'd0);
        check("mid_rst_wdata",     imem_wdata,      32'd0);
        check("mid_rst_core_hold", 32'(core_hold),  32'd1);
        check("mid_rst_done",      32'(done),       32'd0);
        check("mid_rst_err",       32'(err),        32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("mid_rst_nwr",   32'(wr_addr_q.size() - base), 32'd1);
        check("mid_rst_word0", wr_data_q[base], 32'h0050_0013);
        check("mid_rst_idle",  32'(done),       32'd0);
        check("mid_rst_hold",  32'(core_hold),  32'd1);
        tick();

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch for a single word.
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(PROG[i], 0);
        send_byte(8'h63, 0);
        wait_done("csum_ok_done");
        check("csum_ok_err",  32'(err),       32'd0);
        check("csum_ok_hold", 32'(core_hold), 32'd0);
        tick();
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(PROG[i], 0);
        send_byte(8'h64, 0);
        wait_done("csum_bad_done");
        check("csum_bad_err",  32'(err),       32'd1);
        check("csum_bad_hold", 32'(core_hold), 32'd1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
